// File: rtl/pipe_exe_stage.sv
// Execute stage of the 5-stage pipeline: ID/EXE register, ALU with jal link path,
// and EXE/MEM register. EXE-side results feed decode forwarding combinationally.
module pipe_exe_stage #(
    parameter int DATA_W   = 32,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              nostall,
    input  logic              dwreg,
    input  logic              dm2reg,
    input  logic              dwmem,
    input  logic [3:0]        daluc,
    input  logic              daluimm,
    input  logic              dshift,
    input  logic              djal,
    input  logic [DATA_W-1:0] da,
    input  logic [DATA_W-1:0] db,
    input  logic [DATA_W-1:0] dimm,
    input  logic [4:0]        drn,
    input  logic [DATA_W-1:0] dpc4,
    output logic              ewreg,
    output logic              em2reg,
    output logic [4:0]        ern,
    output logic [DATA_W-1:0] ealu,
    output logic              mwreg,
    output logic              mm2reg,
    output logic              mwmem,
    output logic [4:0]        mrn,
    output logic [DATA_W-1:0] malu,
    output logic [DATA_W-1:0] mb
);

    logic              ewmem;
    logic              ejal;
    logic              ealuimm;
    logic              eshift;
    logic [3:0]        ealuc;
    logic [4:0]        ern_dec;
    logic [DATA_W-1:0] ea;
    logic [DATA_W-1:0] eb;
    logic [DATA_W-1:0] eimm;
    logic [DATA_W-1:0] epc4;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_out;

    // ID/EXE: a stall squashes only the side-effecting controls; data still loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            ewreg   <= 1'b0;
            em2reg  <= 1'b0;
            ewmem   <= 1'b0;
            ejal    <= 1'b0;
            ealuimm <= 1'b0;
            eshift  <= 1'b0;
            ealuc   <= '0;
            ern_dec <= '0;
            ea      <= '0;
            eb      <= '0;
            eimm    <= '0;
            epc4    <= '0;
        end else begin
            ewreg   <= dwreg  & nostall;
            em2reg  <= dm2reg & nostall;
            ewmem   <= dwmem  & nostall;
            ejal    <= djal   & nostall;
            ealuimm <= daluimm;
            eshift  <= dshift;
            ealuc   <= daluc;
            ern_dec <= drn;
            ea      <= da;
            eb      <= db;
            eimm    <= dimm;
            epc4    <= dpc4;
        end
    end

    assign alu_a = eshift  ? {{(DATA_W-5){1'b0}}, eimm[10:6]} : ea;
    assign alu_b = ealuimm ? eimm : eb;

    always_comb begin
        alu_out = '0;
        casez (ealuc)
            4'b?000: alu_out = alu_a + alu_b;
            4'b?100: alu_out = alu_a - alu_b;
            4'b?001: alu_out = alu_a & alu_b;
            4'b?101: alu_out = alu_a | alu_b;
            4'b?010: alu_out = alu_a ^ alu_b;
            4'b?110: alu_out = alu_b << 16;
            4'b0011: alu_out = alu_b << alu_a[4:0];
            4'b0111: alu_out = alu_b >> alu_a[4:0];
            4'b1111: alu_out = $unsigned($signed(alu_b) >>> alu_a[4:0]);
            default: alu_out = '0;
        endcase
    end

    assign ern  = ejal ? 5'(LINK_REG) : ern_dec;
    assign ealu = ejal ? epc4 + DATA_W'(4) : alu_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            mwreg  <= 1'b0;
            mm2reg <= 1'b0;
            mwmem  <= 1'b0;
            mrn    <= '0;
            malu   <= '0;
            mb     <= '0;
        end else begin
            mwreg  <= ewreg;
            mm2reg <= em2reg;
            mwmem  <= ewmem;
            mrn    <= ern;
            malu   <= ealu;
            mb     <= eb;
        end
    end

endmodule
